// File: rtl/cpc_bus_pkg.sv
// Shared encodings, state type and helpers for the CPC bus-cycle initiator.
// Also consumed by cpc_bank_shadow when CPC_BANK_SHADOW_EN is defined.
package cpc_bus_pkg;

  localparam int unsigned ADR_W    = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SHADOW_W = 6;

  localparam logic [1:0] OP_MEMRD   = 2'b00;
  localparam logic [1:0] OP_MEMWR   = 2'b01;
  localparam logic [1:0] OP_IOWR    = 2'b10;
  localparam logic [1:0] OP_BANKSEL = 2'b11;

  localparam logic [1:0]       BANK_SEL_PREFIX   = 2'b11;
  localparam logic [ADR_W-1:0] BANK_PORT_DEFAULT = 16'h7F00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TWA,
    ST_TW,
    ST_T3
  } state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } bus_cmd_t;

  // Expansion RAM decode: does CPU segment adr[15:14] map to extra RAM for config bbb?
  function automatic logic extram_decode(input logic [1:0] seg, input logic [2:0] bbb);
    logic hit;
    hit = 1'b0;
    case (bbb)
      3'b000:         hit = 1'b0;
      3'b001, 3'b011: hit = (seg == 2'b11);
      3'b010:         hit = 1'b1;
      default:        hit = (seg == 2'b01);
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cpc_bank_shadow.sv
// Shadow copy of the CPC RAM-expansion bank register plus the extra-RAM hit decode.
// Instantiated by cpc_bus_initiator only when CPC_BANK_SHADOW_EN is defined.
module cpc_bank_shadow
  import cpc_bus_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_io_done,
  input  logic [1:0]          i_adr_hi,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_mreq_b,
  output logic [SHADOW_W-1:0] o_bank_shadow,
  output logic                o_extram_hit
);

  logic [SHADOW_W-1:0] r_shadow;
  logic                w_bank_write;

  // The CPLD decodes a bank write as any I/O write with adr[15]=0 and data 11xxxxxx.
  assign w_bank_write = i_io_done && !i_adr_hi[1] && (i_data[7:6] == BANK_SEL_PREFIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (w_bank_write) begin
      r_shadow <= i_data[SHADOW_W-1:0];
    end
  end

  assign o_bank_shadow = r_shadow;
  assign o_extram_hit  = !i_mreq_b && extram_decode(i_adr_hi, r_shadow[2:0]);

endmodule

// File: rtl/cpc_bus_initiator.sv
// Z80-style bus-cycle generator (mem rd/wr, io wr, bank select) for CPC expansion fixtures.
// Optional bank shadow outputs are enabled by defining CPC_BANK_SHADOW_EN.
module cpc_bus_initiator
  import cpc_bus_pkg::*;
#(
  parameter int unsigned      TSTATE_DIV = 4,
  parameter logic [ADR_W-1:0] BANK_PORT  = BANK_PORT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
`ifdef CPC_BANK_SHADOW_EN
  output logic [SHADOW_W-1:0] bank_shadow,
  output logic                extram_hit,
`endif
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADR_W-1:0]    cmd_adr,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [ADR_W-1:0]    adr,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_en,
  input  logic [DATA_W-1:0]   din,
  output logic                mreq_b,
  output logic                iorq_b,
  output logic                rd_b,
  output logic                wr_b,
  input  logic                wait_b
);

  localparam int unsigned       TICK_W    = (TSTATE_DIV > 1) ? $clog2(TSTATE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TSTATE_DIV - 1);

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [1:0]          r_op;
  logic                r_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [ADR_W-1:0]    r_adr;
  logic [DATA_W-1:0]   r_dout;
  logic                r_dout_en;
  logic                r_mreq_b;
  logic                r_iorq_b;
  logic                r_rd_b;
  logic                r_wr_b;

  bus_cmd_t            w_cmd;
  logic                w_accept;
  logic                w_term;
  logic                w_is_io;
  logic                w_is_rd;
  logic                w_to_t3;

  // Bank select is just an I/O write to BANK_PORT with data 11cccbbb.
  always_comb begin
    w_cmd.op   = cmd_op;
    w_cmd.adr  = cmd_adr;
    w_cmd.data = cmd_data;
    if (cmd_op == OP_BANKSEL) begin
      w_cmd.adr  = BANK_PORT;
      w_cmd.data = {BANK_SEL_PREFIX, cmd_data[5:0]};
    end
  end

  assign w_accept = cmd_valid && r_ready;
  assign w_term   = (r_tick == TICK_LAST);
  assign w_is_io  = (r_op == OP_IOWR) || (r_op == OP_BANKSEL);
  assign w_is_rd  = (r_op == OP_MEMRD);

  // Last wait-sampling tick before T3: this is also where read data is captured.
  assign w_to_t3 = w_term && wait_b &&
                   (((r_state == ST_T2) && !w_is_io) || (r_state == ST_TWA) || (r_state == ST_TW));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tick      <= '0;
      r_op        <= OP_MEMRD;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_adr       <= '0;
      r_dout      <= '0;
      r_dout_en   <= 1'b0;
      r_mreq_b    <= 1'b1;
      r_iorq_b    <= 1'b1;
      r_rd_b      <= 1'b1;
      r_wr_b      <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;

      // Tick wraps on the terminal tick, so every state entry starts at zero.
      if (r_state != ST_IDLE) begin
        r_tick <= w_term ? '0 : r_tick + TICK_W'(1);
      end

      if (w_to_t3 && w_is_rd) begin
        r_rsp_data <= din;
      end

      case (r_state)
        ST_IDLE: begin
          r_ready <= !w_accept;
          if (w_accept) begin
            r_state   <= ST_T1;
            r_op      <= w_cmd.op;
            r_adr     <= w_cmd.adr;
            r_dout    <= w_cmd.data;
            r_dout_en <= (w_cmd.op != OP_MEMRD);
          end
        end
        ST_T1: begin
          if (w_term) begin
            r_state  <= ST_T2;
            r_mreq_b <= w_is_io;
            r_iorq_b <= !w_is_io;
            r_rd_b   <= !w_is_rd;
            r_wr_b   <= w_is_rd;
          end
        end
        ST_T2: begin
          if (w_term) begin
            if (w_is_io)     r_state <= ST_TWA;
            else if (wait_b) r_state <= ST_T3;
            else             r_state <= ST_TW;
          end
        end
        ST_TWA, ST_TW: begin
          if (w_term) begin
            r_state <= wait_b ? ST_T3 : ST_TW;
          end
        end
        ST_T3: begin
          if (w_term) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_dout_en   <= 1'b0;
            r_mreq_b    <= 1'b1;
            r_iorq_b    <= 1'b1;
            r_rd_b      <= 1'b1;
            r_wr_b      <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CPC_BANK_SHADOW_EN
  logic w_io_done;

  assign w_io_done = (r_state == ST_T3) && w_term && w_is_io;

  cpc_bank_shadow u_bank_shadow (
    .clk           (clk),
    .reset         (reset),
    .i_io_done     (w_io_done),
    .i_adr_hi      (r_adr[15:14]),
    .i_data        (r_dout),
    .i_mreq_b      (r_mreq_b),
    .o_bank_shadow (bank_shadow),
    .o_extram_hit  (extram_hit)
  );
`endif

  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign adr       = r_adr;
  assign dout      = r_dout;
  assign dout_en   = r_dout_en;
  assign mreq_b    = r_mreq_b;
  assign iorq_b    = r_iorq_b;
  assign rd_b      = r_rd_b;
  assign wr_b      = r_wr_b;

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed scoreboard bench for cpc_bus_initiator at TSTATE_DIV = 1, 4 and 2.
// Shadow checks are included when CPC_BANK_SHADOW_EN is defined.
`timescale 1ns/1ps
module tb_cpc_bus_initiator;
  import cpc_bus_pkg::*;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid [NI];
  logic        cmd_ready [NI];
  logic [1:0]  cmd_op    [NI];
  logic [15:0] cmd_adr   [NI];
  logic [7:0]  cmd_data  [NI];
  logic        rsp_valid [NI];
  logic [7:0]  rsp_data  [NI];
  logic [15:0] adr       [NI];
  logic [7:0]  dout      [NI];
  logic        dout_en   [NI];
  logic [7:0]  din       [NI];
  logic        mreq_b    [NI];
  logic        iorq_b    [NI];
  logic        rd_b      [NI];
  logic        wr_b      [NI];
  logic        wait_b    [NI];
`ifdef CPC_BANK_SHADOW_EN
  logic [5:0]  bank_shadow [NI];
  logic        extram_hit  [NI];
`endif

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_rd [NI];
  int         n_vec;
  int         n_err;
  int         hin;
  int         hout;
  int         n_rsp;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DIV = (g == 0) ? 1 : ((g == 1) ? 4 : 2);
    cpc_bus_initiator #(.TSTATE_DIV(DIV), .BANK_PORT(BANK_PORT_DEFAULT)) u_dut (
      .clk       (clk),
      .reset     (reset),
`ifdef CPC_BANK_SHADOW_EN
      .bank_shadow (bank_shadow[g]),
      .extram_hit  (extram_hit[g]),
`endif
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op[g]),
      .cmd_adr   (cmd_adr[g]),
      .cmd_data  (cmd_data[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_data  (rsp_data[g]),
      .adr       (adr[g]),
      .dout      (dout[g]),
      .dout_en   (dout_en[g]),
      .din       (din[g]),
      .mreq_b    (mreq_b[g]),
      .iorq_b    (iorq_b[g]),
      .rd_b      (rd_b[g]),
      .wr_b      (wr_b[g]),
      .wait_b    (wait_b[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge and follow it to its response strobe.
  // wait_b is held low for bus cycles k in [wlo, whi); din switches to din1 at cycle din_chg.
  task automatic run_cmd(input int i, input logic [1:0] op, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] din0, input logic [7:0] din1,
                         input int din_chg, input int wlo, input int whi,
                         input int lat, input int strb, input int den, input bit keep,
                         output int h_in, output int h_out);
    exp_t        e;
    exp_t        got;
    logic [15:0] ea;
    logic [7:0]  ew;
    bit          is_io;
    bit          is_rd;
    bit          done;
    int          k;
    int          n_mreq, n_iorq, n_rd, n_wr, n_den, bad_adr, bad_dout;
    is_io = op[1];
    is_rd = (op == OP_MEMRD);
    ea    = (op == OP_BANKSEL) ? BANK_PORT_DEFAULT : a;
    ew    = (op == OP_BANKSEL) ? {2'b11, d[5:0]} : d;
    e.inst = i;
    e.lat  = lat;
    e.data = is_rd ? din0 : last_rd[i];
    if (is_rd) last_rd[i] = din0;
    sb.push_back(e);
    n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0; n_den = 0; bad_adr = 0; bad_dout = 0;
    h_in = 0; h_out = 0;
    chk("ready_at_issue", 32'(cmd_ready[i]), 32'd1);
    cmd_valid[i] = 1'b1;
    cmd_op[i]    = op;
    cmd_adr[i]   = a;
    cmd_data[i]  = d;
    din[i]       = din0;
    wait_b[i]    = !(wlo <= 0 && whi > 0);
    @(posedge clk);
    k = 0;
    done = 1'b0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("ready_drop", 32'(cmd_ready[i]), 32'd0);
        if (!keep) cmd_valid[i] = 1'b0;
      end
      if (k == din_chg) din[i] = din1;
      wait_b[i] = !(k >= wlo && k < whi);
      if (rsp_valid[i] === 1'b1) begin
        done = 1'b1;
      end else begin
        if (mreq_b[i] === 1'b0) n_mreq++;
        if (iorq_b[i] === 1'b0) n_iorq++;
        if (rd_b[i] === 1'b0)   n_rd++;
        if (wr_b[i] === 1'b0)   n_wr++;
        if (dout_en[i] === 1'b1) n_den++;
        if ((mreq_b[i] === 1'b0 || iorq_b[i] === 1'b0) && adr[i] !== ea) bad_adr++;
        if (dout_en[i] === 1'b1 && dout[i] !== ew) bad_dout++;
`ifdef CPC_BANK_SHADOW_EN
        if (extram_hit[i] === 1'b1) begin
          if (mreq_b[i] === 1'b0) h_in++;
          else                    h_out++;
        end
`endif
      end
    end
    chk("rsp_seen", 32'(done), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      if (done) begin
        chk("rsp_data", 32'(rsp_data[got.inst]), 32'(got.data));
        chk("latency", 32'(k - 1), 32'(got.lat));
      end
    end
    chk("idle_strobes", 32'({mreq_b[i], iorq_b[i], rd_b[i], wr_b[i]}), 32'hF);
    chk("idle_dout_en", 32'(dout_en[i]), 32'd0);
    chk("mreq_lo_clks", 32'(n_mreq), 32'(is_io ? 0 : strb));
    chk("iorq_lo_clks", 32'(n_iorq), 32'(is_io ? strb : 0));
    chk("rd_lo_clks", 32'(n_rd), 32'(is_rd ? strb : 0));
    chk("wr_lo_clks", 32'(n_wr), 32'(is_rd ? 0 : strb));
    chk("dout_en_clks", 32'(n_den), 32'(den));
    chk("adr_during_strobe", 32'(bad_adr), 32'd0);
    chk("dout_during_en", 32'(bad_dout), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_op[i]    = 2'b00;
      cmd_adr[i]   = 16'h0000;
      cmd_data[i]  = 8'h00;
      din[i]       = 8'h00;
      wait_b[i]    = 1'b1;
      last_rd[i]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_cmd_ready", 32'(cmd_ready[i]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data[i]), 32'd0);
      chk("rst_adr", 32'(adr[i]), 32'd0);
      chk("rst_dout", 32'(dout[i]), 32'd0);
      chk("rst_dout_en", 32'(dout_en[i]), 32'd0);
      chk("rst_strobes", 32'({mreq_b[i], iorq_b[i], rd_b[i], wr_b[i]}), 32'hF);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("ready_after_reset", 32'(cmd_ready[i]), 32'd1);

    // Mem read, DIV=1
    run_cmd(0, OP_MEMRD, 16'hC123, 8'h00, 8'h5A, 8'h5A, 0, 0, 0, 3, 2, 0, 1'b0, hin, hout);

    // Bank select, DIV=4; cmd_adr must be ignored
    run_cmd(1, OP_BANKSEL, 16'h1234, 8'h0A, 8'h00, 8'h00, 0, 0, 0, 16, 12, 16, 1'b0, hin, hout);
`ifdef CPC_BANK_SHADOW_EN
    chk("bank_shadow", 32'(bank_shadow[1]), 32'h0A);
`endif

    // Mem read at 0x8000, DIV=4, wait_b glitch on a non-terminal T2 tick
    run_cmd(1, OP_MEMRD, 16'h8000, 8'h00, 8'h3C, 8'h3C, 0, 6, 7, 12, 8, 0, 1'b0, hin, hout);
`ifdef CPC_BANK_SHADOW_EN
    chk("extram_hit_in_mreq", 32'(hin), 32'd8);
    chk("extram_hit_outside", 32'(hout), 32'd0);
`endif

    // Mem write, DIV=2, three wait states
    run_cmd(2, OP_MEMWR, 16'h4000, 8'hA5, 8'h00, 8'h00, 0, 0, 9, 12, 10, 12, 1'b0, hin, hout);

    // I/O write, DIV=2, one extra wait after the mandatory TWA
    run_cmd(2, OP_IOWR, 16'h10FE, 8'h42, 8'h00, 8'h00, 0, 0, 7, 10, 8, 10, 1'b0, hin, hout);
`ifdef CPC_BANK_SHADOW_EN
    chk("shadow_not_bank_data", 32'(bank_shadow[2]), 32'd0);
`endif

    // Read with din changing during T3: capture must keep the T2 value
    run_cmd(0, OP_MEMRD, 16'h0100, 8'h00, 8'h11, 8'hEE, 3, 0, 0, 3, 2, 0, 1'b0, hin, hout);

    // Back-to-back with cmd_valid held: second accept in the rsp_valid clk
    run_cmd(0, OP_MEMWR, 16'h1000, 8'h77, 8'h00, 8'h00, 0, 0, 0, 3, 2, 3, 1'b1, hin, hout);
    run_cmd(0, OP_MEMRD, 16'h2000, 8'h00, 8'h99, 8'h99, 0, 0, 0, 3, 2, 0, 1'b0, hin, hout);

    // I/O write, DIV=1
    run_cmd(0, OP_IOWR, 16'h00FE, 8'h55, 8'h00, 8'h00, 0, 0, 0, 4, 3, 4, 1'b0, hin, hout);

    // Reset during T2 of an I/O write
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = OP_IOWR;
    cmd_adr[0]   = 16'h00FE;
    cmd_data[0]  = 8'h33;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    chk("t2_iorq_low", 32'(iorq_b[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", 32'({mreq_b[0], iorq_b[0], rd_b[0], wr_b[0]}), 32'hF);
    chk("mid_rst_dout_en", 32'(dout_en[0]), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NI; i++) last_rd[i] = 8'h00;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("post_rst_rsp_data", 32'(rsp_data[0]), 32'd0);
`ifdef CPC_BANK_SHADOW_EN
    chk("post_rst_shadow", 32'(bank_shadow[1]), 32'd0);
`endif
    n_rsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) n_rsp++;
    end
    chk("dropped_cmd_no_rsp", 32'(n_rsp), 32'd0);

    // Recovery after reset
    run_cmd(0, OP_MEMRD, 16'hFFFF, 8'h00, 8'hC7, 8'hC7, 0, 0, 0, 3, 2, 0, 1'b0, hin, hout);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
